// File: rtl/clock_mode_ctrl.sv
// Debounced three-key mode controller (RESET/SET/START) driving a one-second prescaler.
// Define CLOCK_MODE_CTRL_PAUSE_EN to add a PAUSE mode entered by set while running.
module clock_mode_ctrl #(
    parameter int unsigned TICK_MAX  = 49999999,
    parameter int unsigned DB_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_reset,
    input  logic        key_set,
    input  logic        key_start,
    output logic [3:0]  state,
    output logic [25:0] rCount,
    output logic        canIMove,
    output logic        tick
);

    localparam int unsigned DbW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DbW-1:0] DbLast = DbW'(DB_CYCLES - 1);
    localparam logic [25:0] TickMax = 26'(TICK_MAX);

    typedef enum logic [3:0] {
        StReset = 4'd0,
        StSet   = 4'd1,
`ifdef CLOCK_MODE_CTRL_PAUSE_EN
        StPause = 4'd2,
`endif
        StStart = 4'd3
    } state_e;

    // Key index: 0 reset, 1 set, 2 start.
    logic [2:0]            keys_raw;
    logic [2:0]            sync1_q, sync2_q;
    logic [2:0]            db_q, db_d, db_dly_q;
    logic [2:0]            armed_q, armed_d;
    logic [2:0]            press_q, press_d;
    logic [2:0][DbW-1:0]   db_cnt_q, db_cnt_d;
    logic [1:0]            init_q;
    state_e                state_q, state_d;
    logic [25:0]           rcount_q, rcount_d;

    assign keys_raw = {key_start, key_set, key_reset};

    // A key only arms once it is seen released after reset, so a key held
    // through reset release never produces a press event.
    always_comb begin
        db_d    = db_q;
        armed_d = armed_q;
        for (int i = 0; i < 3; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (db_cnt_q[i] == DbLast) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
                end
            end
            if (init_q[1] && sync2_q[i] && db_q[i]) begin
                armed_d[i] = 1'b1;
            end
        end
        press_d = armed_q & db_dly_q & ~db_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= '1;
            sync2_q  <= '1;
            db_q     <= '1;
            db_dly_q <= '1;
            db_cnt_q <= '0;
            armed_q  <= '0;
            press_q  <= '0;
            init_q   <= '0;
        end else begin
            sync1_q  <= keys_raw;
            sync2_q  <= sync1_q;
            db_q     <= db_d;
            db_dly_q <= db_q;
            db_cnt_q <= db_cnt_d;
            armed_q  <= armed_d;
            press_q  <= press_d;
            init_q   <= {init_q[0], 1'b1};
        end
    end

    always_comb begin
        state_d = state_q;
        if (press_q[0]) begin
            state_d = StReset;
        end else if (press_q[2]) begin
            state_d = StStart;
        end else if (press_q[1]) begin
            if (state_q == StReset) begin
                state_d = StSet;
`ifdef CLOCK_MODE_CTRL_PAUSE_EN
            end else if (state_q == StStart) begin
                state_d = StPause;
`endif
            end
        end

        // Count only while staying in START; entry shows 0 (or the frozen value) first.
        rcount_d = rcount_q;
        if (state_d == StStart && state_q == StStart) begin
            rcount_d = (rcount_q == TickMax) ? '0 : rcount_q + 26'd1;
        end else if (state_d == StReset || state_d == StSet) begin
            rcount_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StReset;
            rcount_q <= '0;
        end else begin
            state_q  <= state_d;
            rcount_q <= rcount_d;
        end
    end

    assign state    = state_q;
    assign rCount   = rcount_q;
    assign canIMove = (state_q == StStart);
    assign tick     = (state_q == StStart) && (rcount_q == TickMax);

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Bench for clock_mode_ctrl: directed mode sequences plus random key activity,
// checked every cycle against a behavioural model (CLOCK_MODE_CTRL_PAUSE_EN aware).
module tb_clock_mode_ctrl;

    localparam int unsigned TickMax  = 9;
    localparam int unsigned DbCycles = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  keys;  // 0 reset, 1 set, 2 start (active-low)
    logic [3:0]  state;
    logic [25:0] rCount;
    logic        canIMove;
    logic        tick;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    clock_mode_ctrl #(
        .TICK_MAX  (TickMax),
        .DB_CYCLES (DbCycles)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_reset (keys[0]),
        .key_set   (keys[1]),
        .key_start (keys[2]),
        .state     (state),
        .rCount    (rCount),
        .canIMove  (canIMove),
        .tick      (tick)
    );

    // Reference model: raw samples delayed two edges, a key level accepted after
    // DbCycles consecutive differing samples, presses acting two edges later.
    int       m_edges;
    int       m_mode;
    int       m_cnt;
    bit [2:0] m_hist[$];
    bit       m_lvl[3];
    bit       m_armed[3];
    int       m_run[3];
    bit       m_p1[3];
    bit       m_p2[3];

    function automatic void m_reset();
        m_edges = 0;
        m_mode  = 0;
        m_cnt   = 0;
        m_hist.delete();
        for (int i = 0; i < 3; i++) begin
            m_lvl[i]   = 1'b1;
            m_armed[i] = 1'b0;
            m_run[i]   = 0;
            m_p1[i]    = 1'b0;
            m_p2[i]    = 1'b0;
        end
    endfunction

    function automatic void m_edge();
        bit [2:0] syn;
        bit [2:0] ev;
        bit       was;
        int       prev;
        if (!rst_n) begin
            m_reset();
            return;
        end
        m_edges++;
        m_hist.push_back(keys);
        if (m_hist.size() > 3) void'(m_hist.pop_front());
        syn = (m_edges >= 3) ? m_hist[0] : 3'b111;
        for (int i = 0; i < 3; i++) begin
            ev[i]   = m_p2[i];
            m_p2[i] = m_p1[i];
            m_p1[i] = 1'b0;
            was     = m_lvl[i];
            if (syn[i] != m_lvl[i]) begin
                m_run[i]++;
                if (m_run[i] == int'(DbCycles)) begin
                    m_run[i] = 0;
                    m_lvl[i] = syn[i];
                    if (!syn[i] && m_armed[i]) m_p1[i] = 1'b1;
                end
            end else begin
                m_run[i] = 0;
            end
            if (m_edges >= 3 && syn[i] && was) m_armed[i] = 1'b1;
        end
        prev = m_mode;
        if (ev[0]) begin
            m_mode = 0;
        end else if (ev[2]) begin
            m_mode = 3;
        end else if (ev[1]) begin
            if (prev == 0) m_mode = 1;
`ifdef CLOCK_MODE_CTRL_PAUSE_EN
            else if (prev == 3) m_mode = 2;
`endif
        end
        if (m_mode == 3 && prev == 3) m_cnt = (m_cnt + 1) % (TickMax + 1);
        else if (m_mode == 0 || m_mode == 1) m_cnt = 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("state", 32'(state), m_mode);
        check("rCount", 32'(rCount), m_cnt);
        check("tick", 32'(tick), 32'(m_mode == 3 && m_cnt == TickMax));
        check("canIMove", 32'(canIMove), 32'(m_mode == 3));
    endtask

    task automatic cycle(input int n);
        repeat (n) begin
            @(posedge clk);
            m_edge();
            #1;
            check_all();
        end
    endtask

    task automatic press(input int k);
        keys[k] = 1'b0;
        cycle(12);
        keys[k] = 1'b1;
        cycle(10);
    endtask

    task automatic wait_rcount(input int v, input string tag);
        int n = 0;
        while (rCount != 26'(v) && n < 40) begin
            cycle(1);
            n++;
        end
        check(tag, 32'(rCount), v);
    endtask

    initial begin
        int hold[3];
        int ticks;
        m_reset();
        rst_n = 1'b0;
        keys  = 3'b011;  // start held through reset
        cycle(3);
        check("reset_state", 32'(state), 0);

        rst_n = 1'b1;
        cycle(15);
        check("held_no_event", 32'(state), 0);
        keys[2] = 1'b1;
        cycle(10);

        // Clean start press: state changes exactly 8 edges after the raw edge.
        keys[2] = 1'b0;
        cycle(7);
        check("start_early", 32'(state), 0);
        cycle(1);
        check("start_latency", 32'(state), 3);
        check("start_rcount0", 32'(rCount), 0);
        cycle(4);
        keys[2] = 1'b1;
        ticks = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1);
            if (tick) ticks++;
        end
        check("tick_every_10", ticks, 2);

        press(0);
        check("reset_press", 32'(state), 0);

        // Bouncing set key: only the final stable low run is accepted.
        keys[1] = 1'b0; cycle(2);
        keys[1] = 1'b1; cycle(2);
        keys[1] = 1'b0; cycle(2);
        keys[1] = 1'b1; cycle(2);
        keys[1] = 1'b0; cycle(12);
        keys[1] = 1'b1; cycle(10);
        check("bounce_set_state", 32'(state), 1);
        check("bounce_set_rcount", 32'(rCount), 0);

        keys[0] = 1'b0;
        keys[2] = 1'b0;
        cycle(12);
        keys[0] = 1'b1;
        keys[2] = 1'b1;
        cycle(10);
        check("reset_over_start", 32'(state), 0);
        check("reset_over_start_move", 32'(canIMove), 0);

        press(2);
        wait_rcount(9, "align_set");
        keys[1] = 1'b0;
        cycle(8);
`ifdef CLOCK_MODE_CTRL_PAUSE_EN
        check("pause_state", 32'(state), 2);
        check("pause_rcount", 32'(rCount), 6);
        cycle(4);
        keys[1] = 1'b1;
        cycle(10);
        check("pause_frozen", 32'(rCount), 6);
        press(2);
        check("resume_state", 32'(state), 3);
`else
        check("set_ignored", 32'(state), 3);
        check("set_ignored_count", 32'(rCount), 7);
        cycle(4);
        keys[1] = 1'b1;
        cycle(10);
`endif

        wait_rcount(5, "align_reset");
        rst_n = 1'b0;
        #1;
        m_reset();
        check_all();
        check("async_state", 32'(state), 0);
        check("async_rcount", 32'(rCount), 0);
        cycle(2);
        rst_n = 1'b1;
        cycle(10);

        for (int i = 0; i < 3; i++) hold[i] = 0;
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 3; i++) begin
                if (hold[i] == 0) begin
                    keys[i] = ~keys[i];
                    if (i == 0 && keys[i]) hold[i] = int'($urandom_range(20, 60));
                    else hold[i] = int'($urandom_range(1, 12));
                end else begin
                    hold[i]--;
                end
            end
            cycle(1);
        end
        keys = 3'b111;
        cycle(20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
